ula_arbiter: RTL and testbench

Shares the single combinational 8-bit ALU (ULA) between two requesters through valid/ready handshakes. A request is granted, its operands and opcode are registered and presented to the ULA for one cycle, and the result and zero flag are captured and returned to the winning requester. The block sits between the ULA and its two clients (e.g. main datapath and address/branch unit). The ULA stays external; this block drives its inputs and samples its outputs.

---
 rtl/ula_pkg.sv | 30 +++
 rtl/ula_arbiter_if.sv | 37 +++
 rtl/ula_rr_pick.sv | 30 +++
 rtl/ula_arbiter.sv | 130 +++++++++++++
 tb/tb_ula_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// +--------------------------------------------------------------------+
// | ula_pkg: opcodes, opcode legality check and arbiter FSM states.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // 100 and 101 have no ULA function behind them.
  function automatic logic op_legal(input logic [2:0] op);
    return (op != 3'b100) && (op != 3'b101);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ula_arbiter_if.sv
// +--------------------------------------------------------------------+
// | ula_arbiter_if: request/response handshakes of the two ULA clients.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface ula_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_z, rsp1_z;
  logic             rsp0_err, rsp1_err;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_z, rsp1_z, rsp0_err, rsp1_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_z, rsp1_z, rsp0_err, rsp1_err
  );
endinterface

`default_nettype wire

// File: rtl/ula_rr_pick.sv
// +--------------------------------------------------------------------+
// | ula_rr_pick: one-hot grant of two requesters. Round-robin on ptr   |
// | with ULA_ARB_RR_EN, fixed priority (req0 first) otherwise.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ula_rr_pick (
  input  logic [1:0] valid,
`ifdef ULA_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ULA_ARB_RR_EN
    if (&valid) grant = ptr ? 2'b10 : 2'b01;
    else        grant = valid;
`else
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/ula_arbiter.sv
// +--------------------------------------------------------------------+
// | ula_arbiter: shares one external 8-bit ULA between two requesters. |
// | Arbitration is round-robin when ULA_ARB_RR_EN is defined.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  ula_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] ula_srca,
  output logic [WIDTH-1:0] ula_srcb,
  output logic [OPW-1:0]   ula_ctrl,
  input  logic [WIDTH-1:0] ula_result,
  input  logic             ula_z
);

  state_t           r_state;
  logic             r_sel;
  logic             r_illegal;
  logic [WIDTH-1:0] r_srca, r_srcb;
  logic [OPW-1:0]   r_ctrl;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_res [2];
  logic [1:0]       r_z;
  logic [1:0]       r_err;
`ifdef ULA_ARB_RR_EN
  logic             r_ptr;
`endif

  logic [1:0]       w_valid, w_grant;
  logic             w_take, w_rsp_ready;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;
  logic [OPW-1:0]   w_sel_op;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  ula_rr_pick u_pick (
    .valid (w_valid),
`ifdef ULA_ARB_RR_EN
    .ptr   (r_ptr),
`endif
    .grant (w_grant)
  );

  assign w_take      = (r_state == S_IDLE) && (|w_grant);
  assign w_sel_a     = w_grant[1] ? bus.req1_a  : bus.req0_a;
  assign w_sel_b     = w_grant[1] ? bus.req1_b  : bus.req0_b;
  assign w_sel_op    = w_grant[1] ? bus.req1_op : bus.req0_op;
  assign w_rsp_ready = r_sel ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready  = (r_state == S_IDLE) && w_grant[0];
  assign bus.req1_ready  = (r_state == S_IDLE) && w_grant[1];
  assign bus.rsp0_valid  = r_rsp_valid[0];
  assign bus.rsp1_valid  = r_rsp_valid[1];
  assign bus.rsp0_result = r_res[0];
  assign bus.rsp1_result = r_res[1];
  assign bus.rsp0_z      = r_z[0];
  assign bus.rsp1_z      = r_z[1];
  assign bus.rsp0_err    = r_err[0];
  assign bus.rsp1_err    = r_err[1];

  // ULA inputs are registers that are nonzero only while in EXEC.
  assign ula_srca = r_srca;
  assign ula_srcb = r_srcb;
  assign ula_ctrl = r_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_illegal   <= 1'b0;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_ctrl      <= '0;
      r_rsp_valid <= 2'b00;
      r_res[0]    <= '0;
      r_res[1]    <= '0;
      r_z         <= 2'b00;
      r_err       <= 2'b00;
`ifdef ULA_ARB_RR_EN
      r_ptr       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_sel     <= w_grant[1];
            r_srca    <= w_sel_a;
            r_srcb    <= w_sel_b;
            r_illegal <= !op_legal(w_sel_op);
            r_ctrl    <= op_legal(w_sel_op) ? w_sel_op : ULA_ADD;
            r_state   <= S_EXEC;
`ifdef ULA_ARB_RR_EN
            // Point at whoever did not just win.
            r_ptr     <= w_grant[0];
`endif
          end
        end
        S_EXEC: begin
          r_srca             <= '0;
          r_srcb             <= '0;
          r_ctrl             <= '0;
          r_res[r_sel]       <= r_illegal ? '0 : ula_result;
          r_z[r_sel]         <= r_illegal ? 1'b1 : ula_z;
          r_err[r_sel]       <= r_illegal;
          r_rsp_valid[r_sel] <= 1'b1;
          r_state            <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_rsp_valid[r_sel] <= 1'b0;
            r_state            <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_ula_arbiter: directed table, corner sequences and random traffic|
// | for ula_arbiter, with a behavioural ULA and arbitration model.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ula_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ula_srca, ula_srcb, ula_result;
  logic [2:0] ula_ctrl;
  logic       ula_z;

  int errors = 0;
  int checks = 0;
  int pref   = 0;
  logic [7:0] pa [2];
  logic [7:0] pb [2];
  logic [2:0] pop [2];

  ula_arbiter_if #(.WIDTH(8), .OPW(3)) bus ();

  ula_arbiter #(.WIDTH(8), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ula_srca   (ula_srca),
    .ula_srcb   (ula_srcb),
    .ula_ctrl   (ula_ctrl),
    .ula_result (ula_result),
    .ula_z      (ula_z)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return ~(a | b);
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  assign ula_result = alu(ula_srca, ula_srcb, ula_ctrl);
  assign ula_z      = (ula_result == 8'd0);

  // {err, z, result} a requester should receive.
  function automatic logic [9:0] model(input logic [7:0] a, b, input logic [2:0] op);
    logic [7:0] r;
    if (op == 3'b100 || op == 3'b101) return {1'b1, 1'b1, 8'h00};
    r = alu(a, b, op);
    return {1'b0, (r == 8'd0), r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rv(input int i);
    return (i == 1) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [7:0] rres(input int i);
    return (i == 1) ? bus.rsp1_result : bus.rsp0_result;
  endfunction
  function automatic logic rz(input int i);
    return (i == 1) ? bus.rsp1_z : bus.rsp0_z;
  endfunction
  function automatic logic rerr(input int i);
    return (i == 1) ? bus.rsp1_err : bus.rsp0_err;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, b, input logic [2:0] op);
    pa[i] = a; pb[i] = b; pop[i] = op;
    if (i == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
    #1;
  endtask

  task automatic drop_req(input int i);
    if (i == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic set_rsp_ready(input int i, input logic v);
    if (i == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  // Runs one grant through EXEC and RESP, holding rsp_ready low for `hold` cycles.
  task automatic serve(input int hold, output int w, output logic [7:0] res,
                       output logic z, output logic err);
    int         exp_w;
    int         cnt;
    logic [9:0] e;
    logic [1:0] v;
    v = {bus.req1_valid, bus.req0_valid};
`ifdef ULA_ARB_RR_EN
    exp_w = (v == 2'b11) ? pref : (v[1] ? 1 : 0);
`else
    exp_w = v[0] ? 0 : 1;
`endif
    w = -1; res = 8'h00; z = 1'b0; err = 1'b0;
    cnt = 0;
    while (!(bus.req0_ready || bus.req1_ready) && cnt < 20) begin
      @(negedge clk); #1;
      cnt++;
    end
    if (!(bus.req0_ready || bus.req1_ready)) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no req_ready within 20 cycles, valid=%b", v);
      return;
    end
    chk("ready_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
    w = bus.req1_ready ? 1 : 0;
    chk("winner", w, exp_w);
    pref = 1 - w;
    e = model(pa[w], pb[w], pop[w]);

    @(negedge clk);
    drop_req(w);
    chk("exec_srca", ula_srca, pa[w]);
    chk("exec_srcb", ula_srcb, pb[w]);
    chk("exec_ctrl", ula_ctrl, e[9] ? 3'b010 : pop[w]);
    chk("exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("exec_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);

    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      chk("resp_valid", rv(w), 1);
      chk("resp_other_valid", rv(1 - w), 0);
      chk("resp_result", rres(w), e[7:0]);
      chk("resp_z", rz(w), e[8]);
      chk("resp_err", rerr(w), e[9]);
      chk("resp_ready_low", {bus.req1_ready, bus.req0_ready}, 0);
      chk("resp_ula_idle", {ula_srca, ula_srcb, ula_ctrl}, 0);
    end
    res = rres(w); z = rz(w); err = rerr(w);
    set_rsp_ready(w, 1'b1);
    @(negedge clk);
    set_rsp_ready(w, 1'b0);
    #1;
    chk("resp_cleared", rv(w), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pref = 0;
    #1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] er;
    logic       ez, ee;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         w, w2;
    logic [7:0] res;
    logic       z, err;

    vecs[0] = '{0, 8'h0F, 8'h01, 3'b010, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h12, 8'h34, 3'b100, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{0, 8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1, 8'h0F, 8'hF0, 3'b011, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{0, 8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h09, 8'h02, 3'b111, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{0, 8'h02, 8'h03, 3'b110, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h01, 8'h01, 3'b101, 8'h00, 1'b1, 1'b1};
    bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                          bus.rsp0_err, bus.rsp1_err, bus.rsp0_z, bus.rsp1_z}, 0);
    chk("reset_results", {bus.rsp0_result, bus.rsp1_result}, 0);
    chk("reset_ula", {ula_srca, ula_srcb, ula_ctrl}, 0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op);
      serve(0, w, res, z, err);
      chk("vec_winner", w, vecs[i].idx);
      chk("vec_result", res, vecs[i].er);
      chk("vec_z", z, vecs[i].ez);
      chk("vec_err", err, vecs[i].ee);
    end

    // Simultaneous pair straight after reset.
    do_reset();
    set_req(0, 8'h05, 8'h05, 3'b110);
    set_req(1, 8'hA0, 8'h05, 3'b001);
    serve(0, w, res, z, err);
    chk("pair1_first", w, 0);
    chk("pair1_first_res", {res, z}, {8'h00, 1'b1});
    serve(0, w, res, z, err);
    chk("pair1_second", w, 1);
    chk("pair1_second_res", {res, z}, {8'hA5, 1'b0});
    set_req(0, 8'h01, 8'h01, 3'b010);
    serve(0, w, res, z, err);
    set_req(0, 8'h11, 8'h22, 3'b001);
    set_req(1, 8'h33, 8'h44, 3'b000);
    serve(0, w, res, z, err);
`ifdef ULA_ARB_RR_EN
    chk("pair2_first", w, 1);
`else
    chk("pair2_first", w, 0);
`endif
    serve(0, w2, res, z, err);
    chk("pair2_second", w2, 1 - w);

    // SLT held in RESP while req1 waits.
    set_req(0, 8'h03, 8'h07, 3'b111);
    chk("slt_ready0", bus.req0_ready, 1);
    @(negedge clk);
    drop_req(0);
    set_req(1, 8'h22, 8'h11, 3'b110);
    chk("slt_exec_ready1", bus.req1_ready, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("slt_valid", bus.rsp0_valid, 1);
      chk("slt_result", bus.rsp0_result, 8'h01);
      chk("slt_ready1", bus.req1_ready, 0);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    chk("slt_cleared", bus.rsp0_valid, 0);
    chk("slt_then_ready1", bus.req1_ready, 1);
    pref = 1;
    serve(0, w, res, z, err);
    chk("slt_follow_winner", w, 1);
    chk("slt_follow_res", res, 8'h11);

    // Reset while req1 is in EXEC.
    set_req(1, 8'h40, 8'h02, 3'b010);
    chk("rst_ready1", bus.req1_ready, 1);
    @(negedge clk);
    drop_req(1);
    chk("rst_exec_ctrl", ula_ctrl, 3'b010);
    rst = 1'b1;
    #1;
    chk("rst_ula", {ula_srca, ula_srcb, ula_ctrl}, 0);
    chk("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_z, bus.rsp1_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pref = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp1_valid, 0);
    end
    set_req(0, 8'h0A, 8'h05, 3'b110);
    set_req(1, 8'h0C, 8'h03, 3'b001);
    serve(0, w, res, z, err);
    chk("rst_winner", w, 0);
    serve(0, w, res, z, err);
    chk("rst_second", w, 1);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode != 1) set_req(0, 8'($urandom), 8'($urandom), 3'($urandom));
      if (mode != 0) set_req(1, 8'($urandom), 8'($urandom), 3'($urandom));
      while (bus.req0_valid || bus.req1_valid) begin
        serve($urandom_range(0, 2), w, res, z, err);
        if (w < 0) begin
          drop_req(0);
          drop_req(1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
